// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier retiring BITS_PER_CYCLE steps per clock,
// with valid/ready handshakes on operand and result sides.
module booth_mult_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("booth_mult_seq: BITS_PER_CYCLE must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, CORR, DONE} state_t;

    state_t               state_q;
    logic [WIDTH:0]       mcand_q;
    logic [WIDTH+1:0]     acc_q, acc_d;
    logic [WIDTH:0]       q_q, q_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 corr_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [2*WIDTH-1:0]   result_q;
    logic [2*WIDTH-1:0]   prod_d;

    // Chained Booth steps: add/sub by Q[1:0], then arithmetic shift {acc,Q}.
    always_comb begin
        acc_d = acc_q;
        q_d   = q_q;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            case (q_d[1:0])
                2'b01:   acc_d = acc_d + {mcand_q[WIDTH], mcand_q};
                2'b10:   acc_d = acc_d - {mcand_q[WIDTH], mcand_q};
                default: ;
            endcase
            q_d   = {acc_d[0], q_d[WIDTH:1]};
            acc_d = {acc_d[WIDTH+1], acc_d[WIDTH+1:1]};
        end
    end

    // Booth sees the multiplier as signed; an unsigned multiplier with MSB set
    // is short by mcand * 2^WIDTH.
    always_comb begin
        prod_d = {acc_q[WIDTH-1:0], q_q[WIDTH:1]}
               + (corr_q ? {mcand_q[WIDTH-1:0], {WIDTH{1'b0}}} : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            corr_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= is_signed ? {in0[WIDTH-1], in0} : {1'b0, in0};
                        acc_q   <= '0;
                        q_q     <= {in1, 1'b0};
                        cnt_q   <= '0;
                        corr_q  <= !is_signed && in1[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= CORR;
                end
                CORR: begin
                    result_q    <= prod_d;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst so operands are never offered while reset is applied.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: defaults (32/4) plus 8-bit builds with
// one and eight Booth steps per clock.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv32, ir32, sg32, ov32, or32, bz32;
    logic [31:0] a32, b32;
    logic [63:0] r32;

    logic        iv8, sg8, or8;
    logic [7:0]  a8, b8;
    logic        ir8a, ov8a, bz8a, ir8b, ov8b, bz8b;
    logic [15:0] r8a, r8b;

    int checks   = 0;
    int failures = 0;

    booth_mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in0(a32), .in1(b32),
        .is_signed(sg32), .out_valid(ov32), .out_ready(or32), .result(r32), .busy(bz32)
    );

    booth_mult_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d8a (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8a), .in0(a8), .in1(b8),
        .is_signed(sg8), .out_valid(ov8a), .out_ready(or8), .result(r8a), .busy(bz8a)
    );

    booth_mult_seq #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_d8b (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8b), .in0(a8), .in1(b8),
        .is_signed(sg8), .out_valid(ov8b), .out_ready(or8), .result(r8b), .busy(bz8b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output logic [63:0] res, output int lat, output int bcnt);
        a32 = a; b32 = b; sg32 = s; iv32 = 1'b1;
        tick;
        iv32 = 1'b0;
        lat  = 0;
        bcnt = bz32 ? 1 : 0;
        while (!ov32 && lat < 40) begin
            tick;
            lat++;
            if (bz32) bcnt++;
        end
        res  = r32;
        or32 = 1'b1;
        tick;
        or32 = 1'b0;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                           output logic [15:0] ra, output int la,
                           output logic [15:0] rb, output int lb);
        a8 = a; b8 = b; sg8 = s; iv8 = 1'b1;
        tick;
        iv8 = 1'b0;
        la = -1; lb = -1; ra = '0; rb = '0;
        for (int n = 0; n < 40 && (la < 0 || lb < 0); n++) begin
            if (ov8a && la < 0) begin la = n; ra = r8a; end
            if (ov8b && lb < 0) begin lb = n; rb = r8b; end
            if (la < 0 || lb < 0) tick;
        end
        or8 = 1'b1;
        tick;
        or8 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        checks++; if (ir32 !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b expected 0", ir32); end
        checks++; if (ov32 !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", ov32); end
        checks++; if (r32 !== 64'd0) begin failures++; $display("FAIL rst_result: got %h expected 0", r32); end
        checks++; if (bz32 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bz32); end
        checks++; if (ov8a !== 1'b0 || ov8b !== 1'b0) begin failures++; $display("FAIL rst_out_valid8: got %b%b expected 00", ov8a, ov8b); end
        rst = 1'b0;
        #1;
        checks++; if (ir32 !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready: got %b expected 1", ir32); end
        checks++; if (ir8a !== 1'b1 || ir8b !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready8: got %b%b expected 11", ir8a, ir8b); end
    endtask

    task automatic test_latency;
        logic [63:0] res; int lat, bc;
        run_op32(32'hFFFFFFFD, 32'd7, 1'b1, res, lat, bc);
        checks++; if (res !== 64'hFFFFFFFFFFFFFFEB) begin failures++; $display("FAIL neg3x7: got %h expected FFFFFFFFFFFFFFEB", res); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL latency: got %0d expected 9", lat); end
        checks++; if (bc !== 9) begin failures++; $display("FAIL busy_cycles: got %0d expected 9", bc); end
    endtask

    task automatic test_all_ones;
        logic [63:0] res; int lat, bc;
        run_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, res, lat, bc);
        checks++; if (res !== 64'hFFFFFFFE00000001) begin failures++; $display("FAIL ones_unsigned: got %h expected FFFFFFFE00000001", res); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL ones_unsigned_lat: got %0d expected 9", lat); end
        run_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, res, lat, bc);
        checks++; if (res !== 64'h0000000000000001) begin failures++; $display("FAIL ones_signed: got %h expected 0000000000000001", res); end
    endtask

    task automatic test_min_values;
        logic [63:0] res; int lat, bc;
        run_op32(32'h80000000, 32'h80000000, 1'b1, res, lat, bc);
        checks++; if (res !== 64'h4000000000000000) begin failures++; $display("FAIL min_signed: got %h expected 4000000000000000", res); end
        run_op32(32'h80000000, 32'h80000000, 1'b0, res, lat, bc);
        checks++; if (res !== 64'h4000000000000000) begin failures++; $display("FAIL min_unsigned: got %h expected 4000000000000000", res); end
        run_op32(32'h80000000, 32'h00000002, 1'b0, res, lat, bc);
        checks++; if (res !== 64'h0000000100000000) begin failures++; $display("FAIL min_x2_unsigned: got %h expected 0000000100000000", res); end
    endtask

    task automatic test_zero;
        logic [63:0] res; int lat, bc;
        run_op32(32'h00000000, 32'h12345678, 1'b0, res, lat, bc);
        checks++; if (res !== 64'd0) begin failures++; $display("FAIL zero_in0: got %h expected 0", res); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL zero_in0_lat: got %0d expected 9", lat); end
        run_op32(32'hDEADBEEF, 32'h00000000, 1'b1, res, lat, bc);
        checks++; if (res !== 64'd0) begin failures++; $display("FAIL zero_in1: got %h expected 0", res); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL zero_in1_lat: got %0d expected 9", lat); end
    endtask

    task automatic test_back_to_back;
        int n;
        a32 = 32'd3; b32 = 32'd4; sg32 = 1'b0; iv32 = 1'b1;
        tick;
        a32 = 32'd100; b32 = 32'd200;
        n = 0;
        while (!ov32 && n < 40) begin tick; n++; end
        checks++; if (n !== 9) begin failures++; $display("FAIL bp_latency: got %0d expected 9", n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ov32 !== 1'b1 || r32 !== 64'd12 || ir32 !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got ov=%b res=%h rdy=%b expected ov=1 res=c rdy=0", i, ov32, r32, ir32);
            end
            tick;
        end
        or32 = 1'b1;
        tick;
        or32 = 1'b0;
        checks++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin failures++; $display("FAIL bp_release: got ov=%b rdy=%b expected ov=0 rdy=1", ov32, ir32); end
        checks++; if (r32 !== 64'd12) begin failures++; $display("FAIL bp_result_held: got %h expected c", r32); end
        tick;
        iv32 = 1'b0;
        n = 0;
        while (!ov32 && n < 40) begin tick; n++; end
        checks++; if (n !== 9) begin failures++; $display("FAIL bp_second_lat: got %0d expected 9", n); end
        checks++; if (r32 !== 64'd20000) begin failures++; $display("FAIL bp_second_result: got %0d expected 20000", r32); end
        or32 = 1'b1;
        tick;
        or32 = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        logic [63:0] res; int lat, bc, seen;
        a32 = 32'h12345678; b32 = 32'd9; sg32 = 1'b1; iv32 = 1'b1;
        tick;
        iv32 = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        checks++; if (ov32 !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", ov32); end
        checks++; if (r32 !== 64'd0) begin failures++; $display("FAIL midrst_result: got %h expected 0", r32); end
        checks++; if (bz32 !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", bz32); end
        rst = 1'b0;
        #1;
        checks++; if (ir32 !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", ir32); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin tick; if (ov32) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_partial: got %0d valid cycles expected 0", seen); end
        run_op32(32'd5, 32'd6, 1'b1, res, lat, bc);
        checks++; if (res !== 64'd30) begin failures++; $display("FAIL midrst_5x6: got %0d expected 30", res); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL midrst_5x6_lat: got %0d expected 9", lat); end
    endtask

    task automatic test_width8;
        logic [15:0] ra, rb; int la, lb;
        run_op8(8'h7F, 8'h81, 1'b1, ra, la, rb, lb);
        checks++; if (ra !== 16'hC0FF) begin failures++; $display("FAIL w8b1_signed: got %h expected c0ff", ra); end
        checks++; if (la !== 9) begin failures++; $display("FAIL w8b1_lat: got %0d expected 9", la); end
        checks++; if (rb !== 16'hC0FF) begin failures++; $display("FAIL w8b8_signed: got %h expected c0ff", rb); end
        checks++; if (lb !== 2) begin failures++; $display("FAIL w8b8_lat: got %0d expected 2", lb); end
        run_op8(8'h7F, 8'h81, 1'b0, ra, la, rb, lb);
        checks++; if (ra !== 16'h3FFF) begin failures++; $display("FAIL w8b1_unsigned: got %h expected 3fff", ra); end
        checks++; if (rb !== 16'h3FFF) begin failures++; $display("FAIL w8b8_unsigned: got %h expected 3fff", rb); end
        checks++; if (la !== 9 || lb !== 2) begin failures++; $display("FAIL w8_unsigned_lat: got %0d/%0d expected 9/2", la, lb); end
    endtask

    initial begin
        rst = 1'b1;
        iv32 = 1'b0; sg32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
        iv8  = 1'b0; sg8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0;
        test_reset;
        test_latency;
        test_all_ones;
        test_min_values;
        test_zero;
        test_back_to_back;
        test_reset_mid_op;
        test_width8;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
